// File: rtl/imm_pkg.sv
// Shared types for the pipelined RISC-V immediate generator: format codes,
// base opcodes, the decoded result record and the skid-buffer states.
package imm_pkg;

  // Widest supported XLEN; narrower builds use the low bits of imm.
  localparam int IMM_W = 64;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_R    = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [IMM_W-1:0] imm;
    fmt_e             fmt;
    logic             illegal;
  } imm_res_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  function automatic logic [IMM_W-1:0] sext32(input logic [31:0] v);
    return {{(IMM_W-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational opcode classifier and immediate former. Every immediate is
// built as a sign-extended 32-bit value, then widened to XLEN.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit B_J_LSB0 = 1'b1
) (
  input  logic [31:0] instr_i,
  output imm_res_t    res_o
);

  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic [31:0] u_imm;
  logic [31:0] imm32;
  logic [IMM_W-1:0] imm_wide;
  logic [IMM_W-1:0] imm_sel;
  fmt_e        fmt;
  logic        illegal;

  assign i_imm = {{20{instr_i[31]}}, instr_i[31:20]};
  assign s_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign u_imm = {instr_i[31:12], 12'b0};

  // Byte offsets carry the implicit zero LSB; halfword offsets are the raw field.
  generate
    if (B_J_LSB0) begin : g_byte_off
      assign b_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      assign j_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
    end else begin : g_half_off
      assign b_imm = {{20{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8]};
      assign j_imm = {{12{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21]};
    end
  endgenerate

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    imm32   = '0;
    case (instr_i[6:0])
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = u_imm;
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = j_imm;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_FENCE, OPC_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = i_imm;
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = s_imm;
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = b_imm;
      end
      OPC_OP: begin
        fmt   = FMT_R;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm_wide = sext32(imm32);
  assign imm_sel  = (XLEN == 64) ? imm_wide : {32'b0, imm_wide[31:0]};
  assign res_o    = {imm_sel, fmt, illegal};

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational decode feeding a 2-entry
// skid buffer, so input ready never depends combinationally on output ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit B_J_LSB0 = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  state_e   state_q;
  imm_res_t main_q;
  imm_res_t skid_q;
  imm_res_t dec_res;
  logic     in_ready_q;
  logic     out_valid_q;
  logic     in_xfer;
  logic     out_xfer;

  imm_decode_comb #(
    .XLEN     (XLEN),
    .B_J_LSB0 (B_J_LSB0)
  ) u_decode (
    .instr_i (instr_i),
    .res_o   (dec_res)
  );

  assign in_xfer  = in_valid_i && in_ready_q;
  assign out_xfer = out_valid_q && out_ready_i;

  // main always holds the oldest result; skid only fills when main is stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_q      <= dec_res;
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= dec_res;
          end else if (in_xfer) begin
            skid_q     <= dec_res;
            state_q    <= ST_TWO;
            in_ready_q <= 1'b0;
          end else if (out_xfer) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            main_q     <= skid_q;
            state_q    <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign fmt_o       = main_q.fmt;
  assign illegal_o   = main_q.illegal;

  generate
    if (XLEN == 64) begin : g_x64
      assign imm_o = main_q.imm;
    end else begin : g_x32
      logic unused_hi;
      assign imm_o     = main_q.imm[31:0];
      assign unused_hi = ^main_q.imm[63:32];
    end
  endgenerate

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed and randomised bench for imm_gen_pipe: XLEN=32, XLEN=64 and a
// halfword-offset build all share one input stream.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;

  logic        rdy32, rdy64, rdyr;
  logic        v32, v64, vr;
  logic [31:0] imm32, immr;
  logic [63:0] imm64;
  fmt_e        f32, f64, fr;
  logic        il32, il64, ilr;

  int errors = 0;
  int checks = 0;

  logic [31:0] p_instr [16];
  logic [31:0] p_e32   [16];
  logic [63:0] p_e64   [16];
  logic [2:0]  p_fmt   [16];
  logic        p_ill   [16];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .B_J_LSB0(1'b1)) dut32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy32),
    .instr_i(instr), .out_valid_o(v32), .out_ready_i(out_ready),
    .imm_o(imm32), .fmt_o(f32), .illegal_o(il32)
  );

  imm_gen_pipe #(.XLEN(64), .B_J_LSB0(1'b1)) dut64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy64),
    .instr_i(instr), .out_valid_o(v64), .out_ready_i(out_ready),
    .imm_o(imm64), .fmt_o(f64), .illegal_o(il64)
  );

  imm_gen_pipe #(.XLEN(32), .B_J_LSB0(1'b0)) dutr (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdyr),
    .instr_i(instr), .out_valid_o(vr), .out_ready_i(out_ready),
    .imm_o(immr), .fmt_o(fr), .illegal_o(ilr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction with the consumer ready; result is due one cycle later.
  task automatic send_one(input int k);
    instr     = p_instr[k];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("dec_valid[%0d]", k), v32, 1'b1);
    chk($sformatf("dec_valid64[%0d]", k), v64, 1'b1);
    chk($sformatf("dec_imm32[%0d]", k), imm32, p_e32[k]);
    chk($sformatf("dec_imm64[%0d]", k), imm64, p_e64[k]);
    chk($sformatf("dec_fmt[%0d]", k), f32, p_fmt[k]);
    chk($sformatf("dec_fmt64[%0d]", k), f64, p_fmt[k]);
    chk($sformatf("dec_ill[%0d]", k), il32, p_ill[k]);
    chk($sformatf("dec_ill64[%0d]", k), il64, p_ill[k]);
    chk($sformatf("dec_illr[%0d]", k), ilr, p_ill[k]);
  endtask

  int cur;
  int q[$];
  logic in_x, out_x;

  initial begin
    p_instr = '{32'hFFF00093, 32'hFE112E23, 32'h00000463, 32'hFFDFF06F,
                32'h123450B7, 32'h800000B7, 32'h00000000, 32'h002081B3,
                32'hFFFFF017, 32'h7FF00013, 32'h00000012, 32'h80000063,
                32'h0FF0000F, 32'hC0102573, 32'h00812083, 32'h00112423};
    p_e32   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFFC,
                32'h12345000, 32'h80000000, 32'h00000000, 32'h00000000,
                32'hFFFFF000, 32'h000007FF, 32'h00000000, 32'hFFFFF000,
                32'h000000FF, 32'hFFFFFC01, 32'h00000008, 32'h00000008};
    p_e64   = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h8, 64'hFFFFFFFFFFFFFFFC,
                64'h0000000012345000, 64'hFFFFFFFF80000000, 64'h0, 64'h0,
                64'hFFFFFFFFFFFFF000, 64'h7FF, 64'h0, 64'hFFFFFFFFFFFFF000,
                64'hFF, 64'hFFFFFFFFFFFFFC01, 64'h8, 64'h8};
    p_fmt   = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd4, 3'd0, 3'd6,
                3'd4, 3'd1, 3'd0, 3'd3, 3'd1, 3'd1, 3'd1, 3'd2};
    p_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    #3;
    chk("rst_valid", v32, 1'b0);
    chk("rst_ready", rdy32, 1'b1);
    chk("rst_imm", imm32, 32'h0);
    chk("rst_fmt", f32, 3'd0);
    chk("rst_ill", il32, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Async reset between edges with a result held in main.
    instr = p_instr[0]; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", v32, 1'b1);
    chk("pre_rst_imm", imm32, 32'hFFFFFFFF);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", v32, 1'b0);
    chk("arst_ready", rdy32, 1'b1);
    chk("arst_imm", imm32, 32'h0);
    chk("arst_imm64", imm64, 64'h0);
    chk("arst_fmt", f32, 3'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Halfword-offset build against the byte-offset one.
    send_one(2);  chk("raw_b", immr, 64'h4);         chk("raw_b_fmt", fr, 3'd3);
    send_one(3);  chk("raw_j", immr, 64'hFFFFFFFE);  chk("raw_j_fmt", fr, 3'd5);
    send_one(11); chk("raw_bneg", immr, 64'hFFFFF800);
    send_one(0);  chk("raw_i", immr, 64'hFFFFFFFF);
    for (int k = 0; k < 16; k++) send_one(k);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_valid", v32, 1'b0);
    chk("drain_validr", vr, 1'b0);

    // Backpressure: 4 back-to-back, consumer stalled 3 cycles from first result.
    out_ready = 1'b0;
    instr = p_instr[4]; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_first_valid", v32, 1'b1);
    chk("bp_first_imm", imm32, 32'h12345000);
    chk("bp_ready_after1", rdy32, 1'b1);
    instr = p_instr[1];
    @(posedge clk); #1;
    chk("bp_ready_fell", rdy32, 1'b0);
    chk("bp_hold1_imm", imm32, 32'h12345000);
    instr = p_instr[9];
    @(posedge clk); #1;
    chk("bp_hold2_imm", imm32, 32'h12345000);
    chk("bp_hold2_fmt", f32, 3'd4);
    chk("bp_hold2_ready", rdy32, 1'b0);
    @(posedge clk); #1;
    chk("bp_hold3_imm", imm32, 32'h12345000);
    chk("bp_hold3_valid", v32, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_out2_imm", imm32, 32'hFFFFFFFC);
    chk("bp_out2_fmt", f32, 3'd2);
    chk("bp_ready_back", rdy32, 1'b1);
    @(posedge clk); #1;
    chk("bp_out3_imm", imm32, 32'h000007FF);
    instr = p_instr[13];
    @(posedge clk); #1;
    chk("bp_out4_imm", imm32, 32'hFFFFFC01);
    chk("bp_out4_valid", v32, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_empty", v32, 1'b0);

    // Random valid/ready against a queue model fed from the table.
    q.delete();
    cur = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!(in_valid && !rdy32)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        cur      = $urandom_range(0, 15);
        instr    = p_instr[cur];
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_x  = in_valid && rdy32;
      out_x = v32 && out_ready;
      if (out_x) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_valid", v32, 1'b0);
        end else begin
          chk("rnd_imm32", imm32, p_e32[q[0]]);
          chk("rnd_imm64", imm64, p_e64[q[0]]);
          chk("rnd_fmt", f32, p_fmt[q[0]]);
          chk("rnd_ill", il32, p_ill[q[0]]);
          void'(q.pop_front());
        end
      end
      if (in_x) q.push_back(cur);
      @(posedge clk); #1;
      chk("rnd_valid", v32, q.size() != 0);
      chk("rnd_ready", rdy32, q.size() < 2);
      chk("rnd_ready64", rdy64, q.size() < 2);
      chk("rnd_validr", vr, q.size() != 0);
    end

    // Fill both entries, then reset mid-operation.
    out_ready = 1'b0; in_valid = 1'b1; instr = p_instr[5];
    for (int i = 0; i < 6 && rdy32; i++) begin
      @(posedge clk); #1;
    end
    chk("two_reached", rdy32, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    q.delete();
    @(posedge clk); #1;
    chk("mrst_valid", v32, 1'b0);
    chk("mrst_ready", rdy32, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_stale", v32, 1'b0);
    end
    send_one(7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
